// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and pointer arithmetic for the fifo_ctrl slice.
// Optional feature macro used by this slice: FIFO_CTRL_ALMOST_EN.
package fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // Modulo-depth increment with an explicit wrap, so non-power-of-two depths work.
    function automatic int ptr_next(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Write stream, read stream and memory-port bundle between fifo_ctrl and its neighbours.
// The controller takes the slave modport; producer/consumer/memory side takes master.
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDRSIZE   = $clog2(DEF_DEPTH)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  mem_wr_en;
    logic [ADDRSIZE-1:0]   mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en;
    logic [ADDRSIZE-1:0]   mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rd_data,
        output in_ready, out_valid, out_data,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rd_data,
        input  in_ready, out_valid, out_data,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
    );

endinterface

// File: rtl/fifo_ctrl_wrap_ctr.sv
// wrap_ctr: modulo-DEPTH counter with increment and synchronous clear,
// used for both the write and read pointers of fifo_ctrl.
module wrap_ctr
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_nxt;

    assign q_nxt = W'(ptr_next(int'(q), DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller in front of an external mem_mod storage array.
// Define FIFO_CTRL_ALMOST_EN to add the registered almost_full output.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDRSIZE   = $clog2(DEPTH),
    parameter int CNTSIZE    = $clog2(DEPTH + 1),
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    fifo_ctrl_if.slave         bus,
    output logic [CNTSIZE-1:0] count
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic               almost_full
`endif
);

    if (DEPTH < 2) begin : g_depth_chk
        $error("fifo_ctrl: DEPTH must be at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_af_chk
        $error("fifo_ctrl: AF_LEVEL must not exceed DEPTH");
    end

    logic [ADDRSIZE-1:0] wr_ptr;
    logic [ADDRSIZE-1:0] rd_ptr;
    logic [CNTSIZE-1:0]  next_count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    assign full  = (count == CNTSIZE'(DEPTH));
    assign empty = (count == '0);

    // rst_n is folded into the handshakes so they drop the instant reset asserts.
    assign bus.in_ready  = rst_n & ~full  & ~flush;
    assign bus.out_valid = rst_n & ~empty & ~flush;

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign bus.mem_wr_en   = push;
    assign bus.mem_wr_addr = wr_ptr;
    assign bus.mem_wr_data = bus.in_data;
    assign bus.mem_rd_en   = ~empty;
    assign bus.mem_rd_addr = rd_ptr;
    assign bus.out_data    = bus.mem_rd_data;

    wrap_ctr #(.DEPTH(DEPTH), .W(ADDRSIZE)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clr   (flush),
        .q     (wr_ptr)
    );

    wrap_ctr #(.DEPTH(DEPTH), .W(ADDRSIZE)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .clr   (flush),
        .q     (rd_ptr)
    );

    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else if (push && !pop) begin
            next_count = count + 1'b1;
        end else if (pop && !push) begin
            next_count = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= ~flush & (next_count >= CNTSIZE'(AF_LEVEL));
        end
    end
`endif

endmodule
